// File: rtl/raster_pkg.sv
// Shared constants, word-0 field layout and read-FSM state type for the
// triangle broadcast path.
package raster_pkg;
   localparam int PKT_WORDS       = 10;
   localparam int IDX_W           = 4;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_WORDS - 1);
   localparam int END_Y_THRESHOLD = 31;

   localparam int Y_START_LSB = 0;
   localparam int Y_START_W   = 6;
   localparam int Y_END_LSB   = 6;
   localparam int Y_END_W     = 6;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_BURST = 2'd1,
      RD_GAP   = 2'd2
   } rd_state_t;

   function automatic logic is_end_tri(input logic [Y_START_W-1:0] y_start);
      return y_start >= Y_START_W'(END_Y_THRESHOLD);
   endfunction
endpackage

// File: rtl/tri_pkt_buffer.sv
// One triangle packet store: PKT_WORDS x LWIDTH words, a write index and a
// full flag that holds the packet until the reader releases it.
module tri_pkt_buffer
   import raster_pkg::*;
#(
   parameter int LWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic                 wr_abort,
   input  logic                 wr_commit,
   input  logic [LWIDTH-1:0]    wr_data,
   input  logic                 free,
   input  logic [IDX_W-1:0]     rd_idx,
   output logic [IDX_W-1:0]     wr_idx,
   output logic                 full,
   output logic [LWIDTH-1:0]    rd_data,
   output logic [Y_START_W-1:0] y_start
);
   logic [LWIDTH-1:0] mem [PKT_WORDS];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_idx <= '0;
         full   <= 1'b0;
      end else begin
         if (free) full <= 1'b0;
         if (wr_abort) begin
            wr_idx <= '0;
         end else if (wr_en) begin
            if (wr_idx == LAST_IDX) begin
               wr_idx <= '0;
               if (wr_commit) full <= 1'b1;
            end else begin
               wr_idx <= wr_idx + IDX_W'(1);
            end
         end
      end
   end

   // Contents are not reset; the full flag alone says whether they are valid.
   always_ff @(posedge clk) begin
      if (wr_en && !wr_abort) mem[wr_idx] <= wr_data;
   end

   assign rd_data = mem[rd_idx];
   assign y_start = mem[0][Y_START_LSB +: Y_START_W];
endmodule

// File: rtl/tri_broadcast.sv
// Ping-pong triangle packet buffer feeding one broadcast bus to all raster cores.
// Define TRI_TLAST_CHECK_EN to check s_last framing and report err_len.
//
// state    | meaning
// RD_IDLE  | waiting for a full read buffer and every core ready
// RD_BURST | presenting words 0..9 of the read buffer, one per cycle
// RD_GAP   | one quiet cycle; read buffer already freed, pointer toggles
module tri_broadcast
   import raster_pkg::*;
#(
   parameter int NUM_CORES = 32,
   parameter int LWIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [LWIDTH-1:0]    s_data,
   input  logic                 s_last,
   input  logic [NUM_CORES-1:0] core_ready,
   output logic                 bcast_handshake,
   output logic [LWIDTH-1:0]    bcast_data,
   output logic                 frame_done,
   output logic                 err_len
);
   rd_state_t            state, state_nxt;
   logic                 wr_sel, rd_sel, end_tri;
   logic                 accept, wr_en, wr_abort, wr_commit, wr_done, burst_last;
   logic [1:0]           full;
   logic [IDX_W-1:0]     rd_cnt, cur_idx;
   logic [IDX_W-1:0]     wr_idx_b  [2];
   logic [LWIDTH-1:0]    rd_data_b [2];
   logic [Y_START_W-1:0] y_start_b [2];

   assign s_ready = !full[wr_sel];
   assign accept  = s_valid && s_ready;
   assign cur_idx = wr_idx_b[wr_sel];

`ifdef TRI_TLAST_CHECK_EN
   logic dropping, err_q, early, missing;

   assign early     = accept && !dropping && s_last && (cur_idx != LAST_IDX);
   assign missing   = accept && !dropping && !s_last && (cur_idx == LAST_IDX);
   assign wr_en     = accept && !dropping;
   assign wr_abort  = early;
   assign wr_commit = s_last;
   assign err_len   = err_q;

   // After a missing s_last, swallow words up to and including the next s_last.
   always_ff @(posedge clk) begin
      if (reset) begin
         dropping <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (accept && dropping && s_last) dropping <= 1'b0;
         else if (missing)                 dropping <= 1'b1;
         if (early || missing) err_q <= 1'b1;
      end
   end
`else
   logic unused_last;

   assign unused_last = s_last;
   assign wr_en       = accept;
   assign wr_abort    = 1'b0;
   assign wr_commit   = 1'b1;
   assign err_len     = 1'b0;
`endif

   assign wr_done    = wr_en && !wr_abort && wr_commit && (cur_idx == LAST_IDX);
   assign burst_last = (state == RD_BURST) && (rd_cnt == LAST_IDX);

   for (genvar i = 0; i < 2; i++) begin : g_buf
      tri_pkt_buffer #(.LWIDTH(LWIDTH)) u_buf (
         .clk       (clk),
         .reset     (reset),
         .wr_en     (wr_en && (wr_sel == 1'(i))),
         .wr_abort  (wr_abort && (wr_sel == 1'(i))),
         .wr_commit (wr_commit),
         .wr_data   (s_data),
         .free      (burst_last && (rd_sel == 1'(i))),
         .rd_idx    (rd_cnt),
         .wr_idx    (wr_idx_b[i]),
         .full      (full[i]),
         .rd_data   (rd_data_b[i]),
         .y_start   (y_start_b[i])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= RD_IDLE;
         rd_cnt  <= '0;
         wr_sel  <= 1'b0;
         rd_sel  <= 1'b0;
         end_tri <= 1'b0;
      end else begin
         state <= state_nxt;
         if (wr_done) wr_sel <= !wr_sel;
         if (burst_last)             rd_cnt <= '0;
         else if (state == RD_BURST) rd_cnt <= rd_cnt + IDX_W'(1);
         if (state == RD_IDLE && state_nxt == RD_BURST)
            end_tri <= is_end_tri(y_start_b[rd_sel]);
         if (state == RD_GAP) rd_sel <= !rd_sel;
      end
   end

   // A packet completing this cycle into the idle read buffer starts the burst
   // on the same edge, so word 0 follows the last input word immediately.
   always_comb begin
      state_nxt       = state;
      bcast_handshake = 1'b0;
      bcast_data      = '0;
      frame_done      = 1'b0;
      case (state)
         RD_IDLE: begin
            if ((full[rd_sel] || (wr_done && (wr_sel == rd_sel))) && (&core_ready))
               state_nxt = RD_BURST;
         end
         RD_BURST: begin
            bcast_handshake = 1'b1;
            bcast_data      = rd_data_b[rd_sel];
            if (rd_cnt == LAST_IDX) state_nxt = RD_GAP;
         end
         RD_GAP: begin
            frame_done = end_tri;
            state_nxt  = RD_IDLE;
         end
         default: state_nxt = RD_IDLE;
      endcase
   end
endmodule

// File: tb/tb_tri_broadcast.sv
// Self-checking bench for tri_broadcast: packet-level scoreboard fed from the
// accepted input stream, checked against every broadcast cycle.
module tb_tri_broadcast;
   localparam int NC = 32;
   localparam int LW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          s_valid;
   logic          s_ready;
   logic [LW-1:0] s_data;
   logic          s_last;
   logic [NC-1:0] core_ready;
   logic          bcast_handshake;
   logic [LW-1:0] bcast_data;
   logic          frame_done;
   logic          err_len;

   tri_broadcast #(.NUM_CORES(NC), .LWIDTH(LW)) dut (
      .clk             (clk),
      .reset           (reset),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .s_data          (s_data),
      .s_last          (s_last),
      .core_ready      (core_ready),
      .bcast_handshake (bcast_handshake),
      .bcast_data      (bcast_data),
      .frame_done      (frame_done),
      .err_len         (err_len)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: packets as word lists.
   logic [LW-1:0] cur[$];
   logic [LW-1:0] exp_q[$];
   bit            exp_end[$];
   bit            m_drop = 1'b0;
   bit            m_err  = 1'b0;
   int            burst_pos  = 0;
   bit            gap_expect = 1'b0;
   bit            fd_exp     = 1'b0;

   task automatic model_commit();
      for (int k = 0; k < 10; k++) exp_q.push_back(cur[k]);
      exp_end.push_back(cur[0][5:0] >= 6'd31);
      cur.delete();
   endtask

   task automatic model_accept(input logic [LW-1:0] d, input logic l);
`ifdef TRI_TLAST_CHECK_EN
      if (m_drop) begin
         if (l) m_drop = 1'b0;
      end else begin
         cur.push_back(d);
         if (l && cur.size() < 10) begin
            cur.delete();
            m_err = 1'b1;
         end else if (cur.size() == 10) begin
            if (l) model_commit();
            else begin
               cur.delete();
               m_drop = 1'b1;
               m_err  = 1'b1;
            end
         end
      end
`else
      cur.push_back(d);
      if (cur.size() == 10) model_commit();
`endif
   endtask

   task automatic model_clear();
      cur.delete();
      exp_q.delete();
      exp_end.delete();
      m_drop     = 1'b0;
      m_err      = 1'b0;
      burst_pos  = 0;
      gap_expect = 1'b0;
   endtask

   // Broadcast monitor: every cycle is compared against the scoreboard.
   always @(negedge clk) begin
      if (!reset) begin
         if (gap_expect) begin
            vectors++;
            if (bcast_handshake !== 1'b0 || frame_done !== fd_exp) begin
               miscompares++;
               $display("FAIL gap_cycle: handshake=%0b frame_done=%0b, required 0/%0b",
                        bcast_handshake, frame_done, fd_exp);
            end
            gap_expect = 1'b0;
         end else begin
            vectors++;
            if (frame_done !== 1'b0) begin
               miscompares++;
               $display("FAIL stray_frame_done: got %0b, required 0", frame_done);
            end
            if (bcast_handshake === 1'b1) begin
               vectors++;
               if (exp_q.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected_word: got %h, required no broadcast", bcast_data);
               end else begin
                  logic [LW-1:0] e;
                  e = exp_q.pop_front();
                  if (bcast_data !== e) begin
                     miscompares++;
                     $display("FAIL bcast_word: got %h, required %h", bcast_data, e);
                  end
                  burst_pos++;
                  if (burst_pos == 10) begin
                     burst_pos  = 0;
                     gap_expect = 1'b1;
                     fd_exp     = exp_end.pop_front();
                  end
               end
            end else begin
               vectors++;
               if (burst_pos != 0 || bcast_data !== '0) begin
                  miscompares++;
                  $display("FAIL burst_stall_or_idle_data: pos=%0d data=%h, required pos 0 data 0",
                           burst_pos, bcast_data);
                  burst_pos = 0;
               end
            end
         end
      end
   end

   task automatic send_word(input logic [LW-1:0] d, input logic l);
      int waited = 0;
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      while (!s_ready && waited < 300) begin
         @(negedge clk);
         waited++;
      end
      vectors++;
      if (!s_ready) begin
         miscompares++;
         $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, waited);
         s_valid = 1'b0;
      end else begin
         model_accept(d, l);
      end
   endtask

   task automatic send_packet(input logic [LW-1:0] w0, input bit gaps);
      for (int i = 0; i < 10; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            @(negedge clk);
            s_valid = 1'b0;
         end
         send_word((i == 0) ? w0 : $urandom, i == 9);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || burst_pos != 0 || gap_expect) && n < 600) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      s_valid    = 1'b0;
      s_data     = '0;
      s_last     = 1'b0;
      core_ready = '1;
      repeat (3) @(posedge clk);
      #1 model_clear();
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (s_ready !== 1'b1 || bcast_handshake !== 1'b0 || bcast_data !== '0 ||
          frame_done !== 1'b0 || err_len !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_values: ready=%0b hs=%0b data=%h fd=%0b err=%0b, required 1 0 0 0 0",
                  s_ready, bcast_handshake, bcast_data, frame_done, err_len);
      end
   endtask

   task automatic test_single_packet();
      for (int i = 0; i < 10; i++) send_word(LW'(32'h100 + i), i == 9);
      @(negedge clk);
      s_valid = 1'b0;
      vectors++;
      if (bcast_handshake !== 1'b1 || bcast_data !== 32'h100) begin
         miscompares++;
         $display("FAIL min_latency: hs=%0b data=%h, required 1 00000100", bcast_handshake, bcast_data);
      end
      drain();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL single_drain: %0d words left, required 0", exp_q.size());
      end
   endtask

   task automatic test_core_stall();
      bit saw = 1'b0;
      core_ready    = '1;
      core_ready[5] = 1'b0;
      fork
         begin
            for (int p = 0; p < 3; p++) send_packet($urandom, 1'b0);
            @(negedge clk);
            s_valid = 1'b0;
         end
         begin
            repeat (50) begin
               @(negedge clk);
               if (bcast_handshake === 1'b1) saw = 1'b1;
            end
            vectors++;
            if (saw) begin
               miscompares++;
               $display("FAIL stall_burst: burst seen while core 5 low, required none");
            end
            vectors++;
            if (s_ready !== 1'b0) begin
               miscompares++;
               $display("FAIL stall_ready: s_ready=%0b with both buffers full, required 0", s_ready);
            end
            core_ready = '1;
         end
      join
      drain();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL stall_drain: %0d words left, required 0", exp_q.size());
      end
   endtask

   task automatic test_end_triangle();
      int pulses = 0;
      send_packet(32'h0000_07DF, 1'b0);
      @(negedge clk);
      s_valid = 1'b0;
      repeat (25) begin
         if (frame_done === 1'b1) pulses++;
         @(negedge clk);
      end
      vectors++;
      if (pulses != 1) begin
         miscompares++;
         $display("FAIL end_triangle: %0d frame_done pulses, required 1", pulses);
      end
   endtask

   task automatic test_reset_midburst();
      int n = 0;
      send_packet($urandom, 1'b0);
      @(negedge clk);
      s_valid = 1'b0;
      while (bcast_handshake !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 model_clear();
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (bcast_handshake !== 1'b0 || s_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL midburst_reset: hs=%0b ready=%0b, required 0 1", bcast_handshake, s_ready);
      end
      send_packet($urandom, 1'b0);
      @(negedge clk);
      s_valid = 1'b0;
      drain();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL post_reset_drain: %0d words left, required 0", exp_q.size());
      end
   endtask

   task automatic test_random_traffic();
      bit done = 1'b0;
      fork
         begin
            for (int p = 0; p < 12; p++) send_packet($urandom, 1'b1);
            @(negedge clk);
            s_valid = 1'b0;
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               core_ready = ($urandom_range(0, 3) == 0) ? NC'($urandom) : '1;
            end
            core_ready = '1;
         end
      join
      drain();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL random_drain: %0d words left, required 0", exp_q.size());
      end
   endtask

   task automatic test_tlast();
      int pad;
      for (int i = 0; i < 7; i++)  send_word(LW'(32'h200 + i), i == 6);
      for (int i = 0; i < 10; i++) send_word(LW'(32'h300 + i), i == 9);
      for (int i = 0; i < 10; i++) send_word(LW'(32'h400 + i), 1'b0);
      send_word(32'h4A0, 1'b0);
      send_word(32'h4A1, 1'b1);
      for (int i = 0; i < 10; i++) send_word(LW'(32'h500 + i), i == 9);
      pad = (cur.size() == 0) ? 0 : 10 - cur.size();
      for (int i = 0; i < pad; i++) send_word(LW'(32'h600 + i), i == pad - 1);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      drain();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL tlast_drain: %0d words left, required 0", exp_q.size());
      end
      vectors++;
      if (err_len !== m_err) begin
         miscompares++;
         $display("FAIL err_len: got %0b, required %0b", err_len, m_err);
      end
      send_packet($urandom, 1'b0);
      @(negedge clk);
      s_valid = 1'b0;
      drain();
      vectors++;
      if (err_len !== m_err || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL err_len_sticky: got %0b left %0d, required %0b left 0",
                  err_len, exp_q.size(), m_err);
      end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_core_stall();
      test_end_triangle();
      test_reset_midburst();
      test_random_traffic();
      test_tlast();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
